// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, bit timing, deserialise,
// start-glitch / parity / stop checking.
//
// Ports:
//   CLK, RST       rising-edge clock, synchronous active-high reset
//   RX_IN          synchronised serial line, idle high
//   prescale       oversampling ratio (even, 8..30), latched per frame
//   PAR_EN         parity bit present after data (latched per frame)
//   PAR_TYP        0 = even parity, 1 = odd parity (latched per frame)
//   sampled_bit    majority result from the data sampler, valid at CAP
//   samp_prescale  frame-latched prescale for the sampler
//   data_samp_en   sampler enable, high for the whole frame
//   edge_counter   oversample index within the current bit
//   bit_counter    bit index within the frame, 0 = start bit
//   P_DATA         last error-free payload
//   data_valid     1-cycle pulse when P_DATA is updated
//   par_err        parity error of last frame, held until next start
//   stp_err        stop error of last frame, held until next start
//   strt_glitch    1-cycle pulse when a start bit is rejected
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic [PRESCALE_W-1:0] samp_prescale,
    output logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_counter,
    output logic [3:0]            bit_counter,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  glitch_q, glitch_d;

    logic [PRESCALE_W-1:0] cap;
    logic                  at_cap;
    logic                  at_wrap;
    logic                  exp_par;

    // The sampler presents its majority vote only at this edge index.
    assign cap     = (psc_q >> 1) + PRESCALE_W'(2);
    assign at_cap  = (edge_q == cap);
    assign at_wrap = (edge_q == psc_q - PRESCALE_W'(1));
    assign exp_par = par_typ_q ? ~^shift_q : ^shift_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            psc_q     <= PRESCALE_W'(8);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            shift_q   <= '0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            psc_q     <= psc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            glitch_q  <= glitch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = '0;
        bit_d     = '0;
        psc_d     = psc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        glitch_d  = 1'b0;

        // Bit timing runs in every active state; IDLE holds both at 0.
        if (state_q != IDLE) begin
            if (at_wrap) begin
                edge_d = '0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
                bit_d  = bit_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    psc_d     = prescale;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (at_cap && sampled_bit) begin
                    glitch_d = 1'b1;
                    state_d  = IDLE;
                    edge_d   = '0;
                    bit_d    = '0;
                end else if (at_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // LSB arrives first, so shifting right leaves it in bit 0.
                if (at_cap) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                end
                if (at_wrap && bit_q == 4'(DATA_WIDTH)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_cap) begin
                    par_err_d = (sampled_bit != exp_par);
                end
                if (at_wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_cap) begin
                    stp_err_d = ~sampled_bit;
                end
                if (at_wrap) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                    if (!par_err_q && !stp_err_q) begin
                        pdata_d = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign samp_prescale = psc_q;
    assign data_samp_en  = (state_q != IDLE);
    assign edge_counter  = edge_q;
    assign bit_counter   = bit_q;
    assign P_DATA        = pdata_q;
    assign data_valid    = valid_q;
    assign par_err       = par_err_q;
    assign stp_err       = stp_err_q;
    assign strt_glitch   = glitch_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a 3-sample majority sampler model.
// Frames are generated on the line and checked against a frame-level model.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          sampled_bit;
    logic [PW-1:0] samp_prescale;
    logic          data_samp_en;
    logic [PW-1:0] edge_counter;
    logic [3:0]    bit_counter;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .prescale      (prescale),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .sampled_bit   (sampled_bit),
        .samp_prescale (samp_prescale),
        .data_samp_en  (data_samp_en),
        .edge_counter  (edge_counter),
        .bit_counter   (bit_counter),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .strt_glitch   (strt_glitch)
    );

    always #5 CLK = ~CLK;

    // Sampler: majority of the three line samples taken just before CAP.
    logic [2:0] smp = 3'b111;
    always @(posedge CLK) smp <= {smp[1:0], RX_IN};
    always_comb begin
        sampled_bit = 1'b0;
        if (data_samp_en &&
            edge_counter == (samp_prescale >> 1) + PW'(2))
            sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) |
                          (smp[1] & smp[2]);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: collects received bytes, latency from START entry, glitches.
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_en = 1'b0;
    int   got_q[$];
    int   lat_q[$];
    int   glitch_n = 0;

    always @(negedge CLK) begin
        cyc++;
        if (data_samp_en && !prev_en) start_cyc = cyc;
        prev_en = data_samp_en;
        if (data_valid) begin
            got_q.push_back(int'(P_DATA));
            lat_q.push_back(cyc - start_cyc);
        end
        if (strt_glitch) glitch_n++;
    end

    // Frame-level reference model.
    int         exp_q[$];
    int         explat_q[$];
    int         exp_glitch = 0;
    logic [7:0] last_good = 8'h00;
    logic       m_par = 1'b0;
    logic       m_stp = 1'b0;

    function automatic int ones(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic good_par(input logic [7:0] d, input logic typ);
        logic e;
        e = logic'(ones(d) % 2);
        return typ ? ~e : e;
    endfunction

    task automatic model(input logic [7:0] d, input logic pen,
                         input logic ptyp, input logic pb,
                         input logic sv, input int p);
        logic bad_p;
        bad_p = pen && (((ones(d) + int'(pb)) % 2) != int'(ptyp));
        m_par = bad_p;
        m_stp = !sv;
        if (!bad_p && sv) begin
            exp_q.push_back(int'(d));
            explat_q.push_back((10 + int'(pen)) * p);
            last_good = d;
        end
    endtask

    task automatic drive(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    // Mid-frame the configuration inputs are disturbed; the DUT must ignore it.
    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pb,
                              input logic sv, input int p, input int pmid);
        prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                prescale = PW'(pmid);
                PAR_EN   = ~pen;
                PAR_TYP  = ~ptyp;
            end
            drive(d[i], p);
        end
        if (pen) drive(pb, p);
        drive(sv, p);
        RX_IN = 1'b1;
    endtask

    task automatic verify(input string tag);
        check({tag, "_nvalid"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_data"}, got_q[i], exp_q[i]);
            check({tag, "_lat"}, lat_q[i], explat_q[i]);
        end
        check({tag, "_pdata"}, P_DATA, last_good);
        check({tag, "_par_err"}, par_err, m_par);
        check({tag, "_stp_err"}, stp_err, m_stp);
        check({tag, "_samp_en"}, data_samp_en, 1'b0);
        check({tag, "_glitch"}, glitch_n, exp_glitch);
        got_q.delete();
        lat_q.delete();
        exp_q.delete();
        explat_q.delete();
        glitch_n   = 0;
        exp_glitch = 0;
    endtask

    task automatic frame(input string tag, input logic [7:0] d,
                         input logic pen, input logic ptyp, input logic pb,
                         input logic sv, input int p);
        model(d, pen, ptyp, pb, sv, p);
        send_frame(d, pen, ptyp, pb, sv, p, p);
        repeat (p + 6) @(negedge CLK);
        verify(tag);
    endtask

    task automatic glitch_case(input string tag, input int p);
        prescale = PW'(p);
        m_par = 1'b0;
        m_stp = 1'b0;
        exp_glitch = 1;
        drive(1'b0, 2);
        drive(1'b1, p + 6);
        verify(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psc"}, samp_prescale, 8);
        check({tag, "_en"}, data_samp_en, 1'b0);
        check({tag, "_edge"}, edge_counter, 0);
        check({tag, "_bit"}, bit_counter, 0);
        check({tag, "_pdata"}, P_DATA, 0);
        check({tag, "_valid"}, data_valid, 1'b0);
        check({tag, "_par"}, par_err, 1'b0);
        check({tag, "_stp"}, stp_err, 1'b0);
        check({tag, "_glitch"}, strt_glitch, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       pen, ptyp, pb, sv;
        int         p;

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        frame("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        frame("t2_3c_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        frame("t2_3c_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8);
        frame("t2_odd", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8);
        glitch_case("t3_glitch", 8);
        frame("t4_stop", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        frame("t4_clear", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 8);

        // Abort a frame with reset while data bit 4 is being received.
        p = 12;
        prescale = PW'(p);
        PAR_EN = 1'b0;
        drive(1'b0, p);
        drive(1'b1, p);
        drive(1'b0, p);
        drive(1'b1, p);
        drive(1'b0, p / 2);
        check("t5_bit_pre_rst", bit_counter, 4);
        RST = 1'b1;
        RX_IN = 1'b1;
        @(negedge CLK);
        check_reset_outputs("t5_rst");
        RST = 1'b0;
        last_good = 8'h00;
        got_q.delete();
        lat_q.delete();
        glitch_n = 0;
        frame("t5_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8);

        // Back-to-back; prescale input drops to 8 in the middle of frame 1.
        model(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        model(8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 16, 8);
        check("t6_psc_held", samp_prescale, 16);
        send_frame(8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 8, 8);
        check("t6_psc_next", samp_prescale, 8);
        repeat (14) @(negedge CLK);
        verify("t6_b2b");

        for (int k = 0; k < 25; k++) begin
            p = 2 * $urandom_range(4, 15);
            if ($urandom_range(0, 9) == 0) begin
                glitch_case("rnd_glitch", p);
            end else begin
                d    = 8'($urandom);
                pen  = 1'($urandom_range(0, 1));
                ptyp = 1'($urandom_range(0, 1));
                pb   = good_par(d, ptyp) ^ ($urandom_range(0, 5) == 0);
                sv   = ($urandom_range(0, 5) != 0);
                frame("rnd", d, pen, ptyp, pb, sv, p);
            end
            repeat ($urandom_range(0, 4)) @(negedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
